// File: rtl/exec_unit.sv
// Single-issue execution unit: register file, one-cycle ALU and an iterative
// shift-add multiplier that stalls issue while it runs.
module exec_unit #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int A0_INDEX      = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     RegWrite,
   input  logic                     ALUsrc,
   input  logic [2:0]               ALUctrl,
   input  logic [DATA_WIDTH-1:0]    immOp,
   input  logic [ADDRESS_WIDTH-1:0] rs1,
   input  logic [ADDRESS_WIDTH-1:0] rs2,
   input  logic [ADDRESS_WIDTH-1:0] rd,
   output logic [DATA_WIDTH-1:0]    ALUout,
   output logic                     EQ,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    a0
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam int SHW   = $clog2(DATA_WIDTH);
   localparam int CW    = $clog2(DATA_WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {
      IDLE,
      MUL_RUN
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   regs [DEPTH];

   logic [DATA_WIDTH-1:0]   op1_p0;
   logic [DATA_WIDTH-1:0]   op2_p0;
   logic [DATA_WIDTH-1:0]   alu_res_p0;
   logic                    accept_p0;

   logic [DATA_WIDTH-1:0]   mcand_p1;
   logic [DATA_WIDTH-1:0]   mplier_p1;
   logic [DATA_WIDTH-1:0]   acc_p1;
   logic [DATA_WIDTH-1:0]   acc_next_p1;
   logic [ADDRESS_WIDTH-1:0] rd_p1;
   logic                    we_p1;
   logic                    eq_p1;
   logic [CW-1:0]           cnt_p1;

   // Single-cycle operations; MUL is handled by the iterative datapath.
   function automatic logic [DATA_WIDTH-1:0] alu_op(
      input logic [2:0]            ctrl,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic signed [DATA_WIDTH-1:0] sa;
      logic signed [DATA_WIDTH-1:0] sb;
      logic [DATA_WIDTH-1:0]        r;
      sa = a;
      sb = b;
      case (ctrl)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLL:  r = a << b[SHW-1:0];
         OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
         default: r = '0;
      endcase
      return r;
   endfunction

   // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   function automatic logic [DATA_WIDTH-1:0] mul_step(
      input logic [DATA_WIDTH-1:0] acc,
      input logic [DATA_WIDTH-1:0] mcand,
      input logic                  mbit
   );
      return acc + (mbit ? mcand : '0);
   endfunction

   assign a0 = regs[A0_INDEX];

   always_comb begin
      op1_p0      = regs[rs1];
      op2_p0      = ALUsrc ? immOp : regs[rs2];
      alu_res_p0  = alu_op(ALUctrl, op1_p0, op2_p0);
      accept_p0   = in_valid && in_ready;
      acc_next_p1 = mul_step(acc_p1, mcand_p1, mplier_p1[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         ALUout    <= '0;
         EQ        <= 1'b0;
         mcand_p1  <= '0;
         mplier_p1 <= '0;
         acc_p1    <= '0;
         rd_p1     <= '0;
         we_p1     <= 1'b0;
         eq_p1     <= 1'b0;
         cnt_p1    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               // Issue stage: operands read combinationally on the acceptance edge
               if (accept_p0) begin
                  if (ALUctrl == OP_MUL) begin
                     mcand_p1  <= op1_p0;
                     mplier_p1 <= op2_p0;
                     acc_p1    <= '0;
                     rd_p1     <= rd;
                     we_p1     <= RegWrite;
                     eq_p1     <= (op1_p0 == op2_p0);
                     cnt_p1    <= CW'(DATA_WIDTH - 1);
                     in_ready  <= 1'b0;
                     state     <= MUL_RUN;
                  end else begin
                     ALUout    <= alu_res_p0;
                     EQ        <= (op1_p0 == op2_p0);
                     out_valid <= 1'b1;
                     if (RegWrite && (rd != '0)) begin
                        regs[rd] <= alu_res_p0;
                     end
                  end
               end
            end
            MUL_RUN: begin
               // Multiply stage: one multiplier bit per cycle, write-back on the last
               acc_p1    <= acc_next_p1;
               mcand_p1  <= mcand_p1 << 1;
               mplier_p1 <= mplier_p1 >> 1;
               cnt_p1    <= cnt_p1 - 1'b1;
               if (cnt_p1 == '0) begin
                  ALUout    <= acc_next_p1;
                  EQ        <= eq_p1;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
                  if (we_p1 && (rd_p1 != '0)) begin
                     regs[rd_p1] <= acc_next_p1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed results for ALU ops, MUL timing,
// issue stall, arithmetic edge cases and reset behaviour.
module tb_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        RegWrite;
   logic        ALUsrc;
   logic [2:0]  ALUctrl;
   logic [31:0] immOp;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] ALUout;
   logic        EQ;
   logic        out_valid;
   logic [31:0] a0;

   int checks = 0;
   int errors = 0;

   exec_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .RegWrite (RegWrite),
      .ALUsrc   (ALUsrc),
      .ALUctrl  (ALUctrl),
      .immOp    (immOp),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .ALUout   (ALUout),
      .EQ       (EQ),
      .out_valid(out_valid),
      .a0       (a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one instruction and return 1 time unit after the next rising edge.
   task automatic issue(input logic [2:0] op, input logic src, input logic [31:0] imm,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic we);
      @(negedge clk);
      in_valid = 1'b1;
      ALUctrl  = op;
      ALUsrc   = src;
      immOp    = imm;
      rs1      = a;
      rs2      = b;
      rd       = d;
      RegWrite = we;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   int low_cnt;
   int pulses;
   int pulse_at;
   logic [31:0] a0_at_pulse;
   logic [31:0] out_at_pulse;
   bit done;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      RegWrite = 1'b0;
      ALUsrc = 1'b0;
      ALUctrl = 3'b000;
      immOp = '0;
      rs1 = '0;
      rs2 = '0;
      rd = '0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_aluout", ALUout, 0);
      check("rst_eq", EQ, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_a0", a0, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // reset, then ADD
      issue(3'b000, 1'b1, 32'd5, 5'd0, 5'd0, 5'd10, 1'b1);
      check("add_a0", a0, 5);
      check("add_out_valid", out_valid, 1);
      check("add_aluout", ALUout, 5);
      check("add_eq", EQ, 0);
      idle();
      @(posedge clk); #1;
      check("add_pulse_end", out_valid, 0);
      check("add_hold", ALUout, 5);

      // back-to-back dependency (x2 preloaded so a zero result is observable)
      issue(3'b000, 1'b1, 32'd99, 5'd0, 5'd0, 5'd2, 1'b1);
      check("b2b_pre_x2", ALUout, 99);
      issue(3'b000, 1'b1, 32'd6, 5'd0, 5'd0, 5'd1, 1'b1);
      check("b2b_x1", ALUout, 6);
      check("b2b_ready0", in_ready, 1);
      issue(3'b001, 1'b0, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1);
      check("b2b_sub", ALUout, 0);
      check("b2b_eq", EQ, 1);
      check("b2b_valid", out_valid, 1);
      check("b2b_ready1", in_ready, 1);
      issue(3'b011, 1'b1, 32'd0, 5'd2, 5'd0, 5'd0, 1'b0);
      check("b2b_x2_read", ALUout, 0);
      check("b2b_ready2", in_ready, 1);

      // MUL latency
      issue(3'b000, 1'b1, 32'd7, 5'd0, 5'd0, 5'd2, 1'b1);
      issue(3'b111, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1);
      check("mul_busy", in_ready, 0);
      check("mul_a0_before", a0, 5);
      low_cnt = in_ready ? 0 : 1;
      pulses = 0;
      pulse_at = 0;
      a0_at_pulse = '0;
      out_at_pulse = '0;
      idle();
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (!in_ready) low_cnt++;
         if (out_valid) begin
            pulses++;
            if (pulse_at == 0) begin
               pulse_at = i;
               a0_at_pulse = a0;
               out_at_pulse = ALUout;
            end
         end
      end
      check("mul_ready_low", low_cnt, 32);
      check("mul_pulses", pulses, 1);
      check("mul_pulse_edge", pulse_at, 32);
      check("mul_a0", a0_at_pulse, 42);
      check("mul_aluout", out_at_pulse, 42);
      check("mul_eq", EQ, 0);

      // stall during MUL
      issue(3'b000, 1'b1, 32'd3, 5'd0, 5'd0, 5'd1, 1'b1);
      issue(3'b000, 1'b1, 32'd4, 5'd0, 5'd0, 5'd2, 1'b1);
      issue(3'b111, 1'b0, 32'd0, 5'd1, 5'd2, 5'd5, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      ALUctrl = 3'b000;
      ALUsrc = 1'b1;
      immOp = 32'd1;
      rs1 = 5'd5;
      rs2 = 5'd0;
      rd = 5'd10;
      RegWrite = 1'b1;
      done = 1'b0;
      pulse_at = 0;
      for (int i = 1; i <= 40 && !done; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            done = 1'b1;
            pulse_at = i;
         end
      end
      check("stall_done", done, 1);
      check("stall_pulse_edge", pulse_at, 32);
      check("stall_mul_out", ALUout, 12);
      check("stall_held_a0", a0, 42);
      check("stall_ready_back", in_ready, 1);
      @(posedge clk); #1;
      check("stall_accept_out", ALUout, 13);
      check("stall_accept_a0", a0, 13);
      check("stall_accept_valid", out_valid, 1);
      idle();

      // arithmetic edges
      issue(3'b000, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd3, 1'b1);
      issue(3'b000, 1'b1, 32'd1, 5'd3, 5'd0, 5'd4, 1'b1);
      check("add_wrap", ALUout, 0);
      issue(3'b110, 1'b1, 32'd1, 5'd3, 5'd0, 5'd0, 1'b0);
      check("slt_neg", ALUout, 1);
      issue(3'b110, 1'b1, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd0, 1'b0);
      check("slt_pos", ALUout, 0);
      issue(3'b101, 1'b1, 32'd33, 5'd1, 5'd0, 5'd0, 1'b0);
      check("sll_33", ALUout, 6);
      issue(3'b010, 1'b1, 32'h0000_0F0F, 5'd3, 5'd0, 5'd0, 1'b0);
      check("and_op", ALUout, 32'h0000_0F0F);
      issue(3'b100, 1'b1, 32'h0000_00FF, 5'd3, 5'd0, 5'd0, 1'b0);
      check("xor_op", ALUout, 32'hFFFF_FF00);
      issue(3'b000, 1'b1, 32'd0, 5'd3, 5'd0, 5'd0, 1'b1);
      check("x0_write_result", ALUout, 32'hFFFF_FFFF);
      issue(3'b011, 1'b1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      check("x0_stays_zero", ALUout, 0);
      check("x0_eq", EQ, 1);
      issue(3'b000, 1'b1, 32'd0, 5'd4, 5'd0, 5'd0, 1'b0);
      check("x4_wrapped", ALUout, 0);
      idle();

      // reset mid-MUL (x1=3, x2=4, a0 currently 13)
      issue(3'b111, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1);
      idle();
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_aluout", ALUout, 0);
      check("midrst_eq", EQ, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_a0", a0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready", in_ready, 1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      check("midrst_no_write", a0, 0);

      // accept on the first edge after reset release
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1;
      ALUctrl = 3'b000;
      ALUsrc = 1'b1;
      immOp = 32'd9;
      rs1 = 5'd0;
      rs2 = 5'd0;
      rd = 5'd10;
      RegWrite = 1'b1;
      @(posedge clk); #1;
      check("first_edge_a0", a0, 9);
      check("first_edge_valid", out_valid, 1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
